// File: rtl/conv_seq_checker_pkg.sv
// conv_pkg: shared types and reference functions for the code-converter checker.
// Holds the FSM state enum, code width, excess-3 offset and expected-value helpers.
package conv_pkg;

  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] EXS_OFFSET = 4'd3;
  localparam logic [CODE_W-1:0] CODE_LAST = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FWD,
    S_REV,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [CODE_W-1:0] g;
    logic [CODE_W-1:0] x;
    logic [CODE_W-1:0] b1;
    logic [CODE_W-1:0] b2;
  } samp_t;

  function automatic logic [CODE_W-1:0] gray_of(
    input logic [CODE_W-1:0] code
  );
    return code ^ (code >> 1);
  endfunction

  // Wraps mod 16: 13->0, 14->1, 15->2.
  function automatic logic [CODE_W-1:0] exs_of(
    input logic [CODE_W-1:0] code
  );
    return code + EXS_OFFSET;
  endfunction

endpackage

// File: rtl/conv_seq_checker_if.sv
// conv_seq_checker_if: bus between the sequencer/checker and the code converter.
// master = checker (drives din_out and enables), slave = converter (drives results).
interface conv_seq_checker_if;

  logic [3:0] din_out;
  logic       gcon;
  logic       xscon;
  logic       bcon1;
  logic       bcon2;
  logic [3:0] gout;
  logic [3:0] xsout;
  logic [3:0] bout1;
  logic [3:0] bout2;

  modport master (
    output din_out,
    output gcon,
    output xscon,
    output bcon1,
    output bcon2,
    input  gout,
    input  xsout,
    input  bout1,
    input  bout2
  );

  modport slave (
    input  din_out,
    input  gcon,
    input  xscon,
    input  bcon1,
    input  bcon2,
    output gout,
    output xsout,
    output bout1,
    output bout2
  );

endinterface

// File: rtl/conv_seq_checker_expect.sv
// conv_expect: combinational expected values for one code under test.
// In: code. Out: exp_g (Gray), exp_x (excess-3), exp_b (round-trip binary).
module conv_expect
  import conv_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [CODE_W-1:0] exp_g,
  output logic [CODE_W-1:0] exp_x,
  output logic [CODE_W-1:0] exp_b
);

  assign exp_g = gray_of(code);
  assign exp_x = exs_of(code);
  assign exp_b = code;

endmodule

// File: rtl/conv_seq_checker.sv
// conv_seq_checker: synchronous sequencer and round-trip checker for the converter.
// Ports: clk, rst_n, start/sweep/din_in control, cv bus, busy/stop/pass/err_cnt/fail_code.
module conv_seq_checker
  import conv_pkg::*;
#(
  parameter int HOLD_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sweep,
  input  logic [CODE_W-1:0] din_in,
  conv_seq_checker_if.master cv,
  output logic              busy,
  output logic              stop,
  output logic              pass,
  output logic [4:0]        err_cnt,
  output logic [CODE_W-1:0] fail_code
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

  state_t            state_q, state_d;
  logic [3:0]        hold_q, hold_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              mode_q, mode_d;
  logic [4:0]        err_q, err_d;
  logic [CODE_W-1:0] fail_q, fail_d;
  logic              first_q, first_d;
  samp_t             samp_q;

  logic [CODE_W-1:0] din_q;
  logic              fwd_en_q;
  logic              rev_en_q;
  logic              busy_q;
  logic              stop_q;
  logic              pass_q;

  logic [CODE_W-1:0] exp_g;
  logic [CODE_W-1:0] exp_x;
  logic [CODE_W-1:0] exp_b;
  logic              hold_last;
  logic              bad;

  conv_expect u_expect (
    .code  (code_q),
    .exp_g (exp_g),
    .exp_x (exp_x),
    .exp_b (exp_b)
  );

  assign hold_last = (hold_q == HOLD_LAST);

  // 4-state compare so an undriven converter output is a fail.
  always_comb begin
    bad = 1'b0;
    if (samp_q.g !== exp_g)  bad = 1'b1;
    if (samp_q.x !== exp_x)  bad = 1'b1;
    if (samp_q.b1 !== exp_b) bad = 1'b1;
    if (samp_q.b2 !== exp_b) bad = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    code_d  = code_q;
    mode_d  = mode_q;
    err_d   = err_q;
    fail_d  = fail_q;
    first_d = first_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = sweep;
          code_d  = sweep ? '0 : din_in;
          err_d   = '0;
          fail_d  = '0;
          first_d = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        hold_d  = '0;
        state_d = S_FWD;
      end
      S_FWD: begin
        if (hold_last) begin
          hold_d  = '0;
          state_d = S_REV;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      S_REV: begin
        if (hold_last) begin
          hold_d  = '0;
          state_d = S_CHECK;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      S_CHECK: begin
        if (bad) begin
          err_d = err_q + 5'd1;
          if (!first_q) begin
            fail_d  = code_q;
            first_d = 1'b1;
          end
        end
        if (mode_q && (code_q != CODE_LAST))
          state_d = S_NEXT;
        else
          state_d = S_DONE;
      end
      S_NEXT: begin
        code_d  = code_q + 4'd1;
        state_d = S_LOAD;
      end
      S_DONE: begin
        // Wait for start to drop so a held start cannot retrigger.
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      code_q  <= '0;
      mode_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      code_q  <= code_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      first_q <= first_d;
    end
  end

  // Samples are taken on the edge that ends each hold phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= '0;
    end else begin
      if (state_q == S_FWD && hold_last) begin
        samp_q.g <= cv.gout;
        samp_q.x <= cv.xsout;
      end
      if (state_q == S_REV && hold_last) begin
        samp_q.b1 <= cv.bout1;
        samp_q.b2 <= cv.bout2;
      end
    end
  end

  // Outputs decode the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q    <= '0;
      fwd_en_q <= 1'b0;
      rev_en_q <= 1'b0;
      busy_q   <= 1'b0;
      stop_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      if (state_d == S_LOAD) din_q <= code_d;
      fwd_en_q <= (state_d == S_FWD) || (state_d == S_REV);
      rev_en_q <= (state_d == S_REV);
      busy_q   <= (state_d != S_IDLE) && (state_d != S_DONE);
      stop_q   <= (state_d == S_DONE);
      pass_q   <= (state_d == S_DONE) && (err_d == 5'd0);
    end
  end

  assign cv.din_out = din_q;
  assign cv.gcon    = fwd_en_q;
  assign cv.xscon   = fwd_en_q;
  assign cv.bcon1   = rev_en_q;
  assign cv.bcon2   = rev_en_q;

  assign busy      = busy_q;
  assign stop      = stop_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_code = fail_q;

endmodule

// File: tb/tb_conv_seq_checker.sv
// tb_conv_seq_checker: randomized bench with a converter model and run-level scoreboard.
// Expected counts, first-fail code and DONE timing come from the run rules.
module tb_conv_seq_checker;

  localparam int H = 2;
  localparam int SINGLE_EDGES = 3 + 2 * H;
  localparam int SWEEP_EDGES = 1 + 16 * (2 + 2 * H) + 15;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sweep;
  logic [3:0] din_in;
  logic       busy;
  logic       stop;
  logic       pass;
  logic [4:0] err_cnt;
  logic [3:0] fail_code;

  logic [15:0] bad_mask;
  logic        kill;

  int n_chk;
  int n_err;

  logic [3:0] fwd_g;
  logic [3:0] fwd_x;
  logic [3:0] xs15;
  logic [4:0] err_at1;
  int         edges;

  conv_seq_checker_if cv();

  conv_seq_checker #(.HOLD_CYC(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sweep     (sweep),
    .din_in    (din_in),
    .cv        (cv),
    .busy      (busy),
    .stop      (stop),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_code (fail_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Converter model; bad_mask flips gout bit 0 for selected codes,
  // kill makes every output unknown.
  logic [3:0] g_raw;
  assign g_raw = (cv.din_out ^ (cv.din_out >> 1))
               ^ {3'b000, bad_mask[cv.din_out]};
  assign cv.gout  = (cv.gcon && !kill) ? g_raw : 4'bxxxx;
  assign cv.xsout = (cv.xscon && !kill) ? cv.din_out + 4'd3 : 4'bxxxx;
  assign cv.bout1 = (cv.bcon1 && !kill) ? g2b(cv.gout) : 4'bxxxx;
  assign cv.bout2 = (cv.bcon2 && !kill) ? cv.xsout - 4'd3 : 4'bxxxx;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input bit sw, input logic [3:0] d, input bit keep);
    @(posedge clk);
    #1;
    start = 1'b1;
    sweep = sw;
    din_in = d;
    edges = 0;
    while (edges < 400) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1) err_at1 = err_cnt;
      if (edges == 2) begin
        fwd_g = cv.gout;
        fwd_x = cv.xsout;
      end
      if (cv.gcon && cv.din_out == 4'hF) xs15 = cv.xsout;
      if (stop) break;
    end
    if (!keep) start = 1'b0;
  endtask

  task automatic score(input string tag, input bit sw, input logic [3:0] d);
    int   e_err;
    logic [3:0] e_fc;
    bit   seen;
    e_err = 0;
    e_fc = 4'd0;
    seen = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (sw || c == int'(d)) begin
        if (kill || bad_mask[c]) begin
          e_err++;
          if (!seen) begin
            e_fc = 4'(c);
            seen = 1'b1;
          end
        end
      end
    end
    chk({tag, ".edges"}, edges, sw ? SWEEP_EDGES : SINGLE_EDGES);
    chk({tag, ".stop"}, stop, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".err"}, err_cnt, e_err);
    chk({tag, ".fcode"}, fail_code, e_fc);
    chk({tag, ".pass"}, pass, e_err == 0);
    chk({tag, ".clr"}, err_at1, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".stop"}, stop, 0);
    chk({tag, ".pass"}, pass, 0);
    chk({tag, ".err"}, err_cnt, 0);
    chk({tag, ".fcode"}, fail_code, 0);
    chk({tag, ".din"}, cv.din_out, 0);
    chk({tag, ".en"}, {cv.gcon, cv.xscon, cv.bcon1, cv.bcon2}, 0);
  endtask

  initial begin
    int waited;
    logic [3:0] d;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    sweep = 1'b0;
    din_in = 4'd0;
    bad_mask = 16'h0;
    kill = 1'b0;
    xs15 = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_zero("rst");

    run(1'b0, 4'b1011, 1'b0);
    score("single11", 1'b0, 4'b1011);
    chk("fwd.gout", fwd_g, 4'b1110);
    chk("fwd.xsout", fwd_x, 4'b1110);

    run(1'b1, 4'd0, 1'b0);
    score("sweep", 1'b1, 4'd0);
    chk("xs15", xs15, 4'b0010);

    bad_mask = 16'h0220;
    run(1'b1, 4'd0, 1'b0);
    score("sweep59", 1'b1, 4'd0);
    bad_mask = 16'h0;

    kill = 1'b1;
    run(1'b0, 4'd3, 1'b0);
    score("xcode3", 1'b0, 4'd3);
    kill = 1'b0;

    @(posedge clk);
    #1;
    start = 1'b1;
    sweep = 1'b1;
    waited = 0;
    while (!cv.bcon1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("midrev.reach", cv.bcon1, 1);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("midrev");
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 4'd0, 1'b0);
    score("afterrst", 1'b0, 4'd0);

    kill = 1'b1;
    run(1'b0, 4'd3, 1'b1);
    score("hold", 1'b0, 4'd3);
    kill = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("hold.stop", stop, 1);
    chk("hold.busy", busy, 0);
    chk("hold.err", err_cnt, 1);
    start = 1'b0;
    run(1'b0, 4'd6, 1'b0);
    score("rerun", 1'b0, 4'd6);

    for (int i = 0; i < 8; i++) begin
      d = 4'($urandom_range(0, 15));
      bad_mask = 16'($urandom);
      run(1'b0, d, 1'b0);
      score($sformatf("rs%0d", i), 1'b0, d);
    end

    for (int i = 0; i < 3; i++) begin
      bad_mask = 16'($urandom) & 16'($urandom);
      run(1'b1, 4'($urandom_range(0, 15)), 1'b0);
      score($sformatf("rw%0d", i), 1'b1, 4'd0);
    end
    bad_mask = 16'h0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
